pe_result_drain: RTL and testbench
==================================

// Module: pe_result_drain
// PURPOSE
//  Output side of the signed PE timing protocol. Signed accumulator results leave the
//  PE array under data_out_valid pulses. The free-running metronome cannot be stalled.
//  This block scales and saturates each result, tags its element index and vector-last,
//  and buffers it in a small FIFO. It hands results to the device through a valid/ready handshake.
//  It flags overflow when the device cannot keep up.
// PARAMETERS
//  N      16  elements per vector (matches metronome length); IDX_W = clog2(N)
//  IN_W   24  signed accumulator width from PE
//  OUT_W  16  signed result width to device
//  SHIFT  4   arithmetic right shift applied before saturation (0..IN_W-OUT_W)
//  DEPTH  4   FIFO entries, power of two, >=2
// PORTS
//  clk              in   1       system clock, rising edge
//  rst              in   1       asynchronous active-low reset
//  data_out_valid   in   1       one-cycle strobe per PE result (from metronome)
//  data_out         in   IN_W    signed PE result, valid with strobe
//  device_out_valid out  1       FIFO head valid
//  device_out_ready in   1       device accepts head this cycle
//  device_out_data  out  OUT_W   scaled/saturated signed result
//  device_out_idx   out  IDX_W   element index 0..N-1 of head
//  device_out_last  out  1       head is element N-1
//  vector_done      out  1       1-cycle pulse: element N-1 popped
//  overflow         out  1       sticky: strobe arrived while FIFO full and no pop
//  busy             out  1       state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, wr/rd ptrs=0, idx=0, state=IDLE; all outputs 0.
//  Quantize (combinational, pre-FIFO): q = data_out >>> SHIFT (sign-preserving, floor);
//   if q > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; if q < -2^(OUT_W-1) -> -2^(OUT_W-1).
//  Push: data_out_valid && (!full || pop) -> write {q, idx, idx==N-1} at wr_ptr.
//   The written entry appears at the head one cycle later. There is no same-cycle bypass.
//  Pop: device_out_valid && device_out_ready. Head outputs are registered from the FIFO
//   and stay stable while valid && !ready.
//  Full and push+pop in the same cycle: both happen and the occupancy is unchanged. No overflow.
//  Full and push without pop: the result is dropped and overflow is set (sticky until reset).
//   idx still advances, so later indices stay aligned with the metronome.
//  Index counter: idx increments on every strobe, dropped or not. It wraps N-1 -> 0.
//  FSM (3 states):
//   IDLE    : idx=0; first strobe -> COLLECT
//   COLLECT : strobe with idx==N-1 -> FLUSH (idx wraps to 0)
//   FLUSH   : the last element is in the FIFO. Pop of the last entry -> IDLE.
//             A strobe in FLUSH is legal (the next vector has started). It is pushed with
//             idx=0 and sets the next state to COLLECT once the last entry is popped.
//  vector_done: registered. It goes high the cycle after the pop of an entry with last=1.
//   It fires for every such pop, regardless of state.
//  busy: combinational from state and the FIFO empty flag.
//  No other error conditions exist. data_out is ignored when the strobe is low.
// STRUCTURE
//  Shared package pe_pkg: IN_W/OUT_W defaults, the sat_shift function (also used by the PE
//   quantizer), and the drain state encoding localparams {IDLE, COLLECT, FLUSH}.
//  Sub-module: pe_sync_fifo (DEPTH x (OUT_W+IDX_W+1), registered head, full/empty,
//   simultaneous push/pop on full). The FSM, index counter and quantizer stay in the top.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles with strobes active -> all outputs 0, FIFO stays empty.
//  2 Stream N=16 strobes, ready=1: data_out=k*32 -> device_out_data=k*2 and idx=k.
//    last is high only at k=15. vector_done pulses once. overflow=0. busy falls after the last pop.
//  3 Saturation (SHIFT=4): 24'h7FFFFF -> 16'h7FFF; 24'h800000 -> 16'h8000;
//    -24'd17 -> -16'd2 (floor).
//  4 Backpressure: ready=0 and 6 strobes -> 4 buffered, overflow=1 after the 5th.
//    Then release ready -> idx 0..3 drain in order, and the next strobe carries idx=6.
//  5 Full with simultaneous push and pop: occupancy stays 4, overflow stays 0, order preserved.
//  6 Back-to-back vectors: 32 strobes, ready=1 -> two vector_done pulses, idx wraps 15->0.
//    The FSM passes FLUSH->COLLECT without IDLE.
//    Then assert rst mid-vector at element 7 -> FIFO cleared, and the next strobe gets idx=0.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared PE widths, drain FSM encoding and the scale/saturate helper
package pe_pkg;

  localparam int PE_IN_W  = 24;
  localparam int PE_OUT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2
  } drain_state_e;

  // Floor-shift then clamp into the signed output range.
  function automatic logic signed [PE_OUT_W-1:0] sat_shift(
    input logic signed [PE_IN_W-1:0] x,
    input int unsigned               shift
  );
    logic signed [PE_IN_W-1:0] q;
    logic signed [PE_IN_W-1:0] sat_max;
    logic signed [PE_IN_W-1:0] sat_min;
    sat_max = PE_IN_W'((1 << (PE_OUT_W - 1)) - 1);
    sat_min = ~sat_max;
    q = x >>> shift;
    if (q > sat_max) begin
      return sat_max[PE_OUT_W-1:0];
    end else if (q < sat_min) begin
      return sat_min[PE_OUT_W-1:0];
    end
    return q[PE_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// rtl/pe_sync_fifo.sv - small synchronous FIFO with flop-based head and push+pop on full
module pe_sync_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_data_o,
  output logic         head_valid_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_en;
  logic          rd_en;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (AW+1)'(DEPTH));
  assign head_valid_o = ~empty_o;
  assign head_data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the push lands in, so full+push+pop is legal.
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - quantize, tag and buffer PE results for a valid/ready device port
module pe_result_drain
  import pe_pkg::*;
#(
  parameter int N     = 16,
  parameter int IN_W  = PE_IN_W,
  parameter int OUT_W = PE_OUT_W,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_out_valid,
  input  logic [IN_W-1:0]          data_out,
  output logic                     device_out_valid,
  input  logic                     device_out_ready,
  output logic [OUT_W-1:0]         device_out_data,
  output logic [$clog2(N)-1:0]     device_out_idx,
  output logic                     device_out_last,
  output logic                     vector_done,
  output logic                     overflow,
  output logic                     busy
);

  localparam int IDX_W   = $clog2(N);
  localparam int ENTRY_W = OUT_W + IDX_W + 1;

  drain_state_e     state_q, state_d;
  logic             next_vec_q, next_vec_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic             vector_done_q, vector_done_d;

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               head_valid;
  logic               push;
  logic               pop;
  logic               idx_last;
  logic [OUT_W-1:0]   q_data;

  assign idx_last   = (idx_q == IDX_W'(N - 1));
  assign q_data     = sat_shift(data_out, SHIFT);
  assign push_entry = {q_data, idx_q, idx_last};
  assign pop        = head_valid & device_out_ready;
  assign push       = data_out_valid & (~fifo_full | pop);

  pe_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .head_data_o  (head_entry),
    .head_valid_o (head_valid),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign device_out_valid = head_valid;
  assign device_out_data  = head_entry[ENTRY_W-1 -: OUT_W];
  assign device_out_idx   = head_entry[1 +: IDX_W];
  assign device_out_last  = head_entry[0];
  assign vector_done      = vector_done_q;
  assign overflow         = overflow_q;
  assign busy             = (state_q != ST_IDLE) | ~fifo_empty;

  always_comb begin
    state_d       = state_q;
    next_vec_d    = next_vec_q;
    idx_d         = idx_q;
    overflow_d    = overflow_q | (data_out_valid & fifo_full & ~pop);
    vector_done_d = pop & device_out_last;

    // The index tracks the metronome even when a result is dropped.
    if (data_out_valid) begin
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (data_out_valid) begin
          state_d = idx_last ? ST_FLUSH : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (data_out_valid && idx_last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (data_out_valid) begin
          next_vec_d = 1'b1;
        end
        if (pop && device_out_last) begin
          state_d    = (next_vec_q || data_out_valid) ? ST_COLLECT : ST_IDLE;
          next_vec_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        next_vec_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      next_vec_q    <= 1'b0;
      idx_q         <= '0;
      overflow_q    <= 1'b0;
      vector_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_vec_q    <= next_vec_d;
      idx_q         <= idx_d;
      overflow_q    <= overflow_d;
      vector_done_q <= vector_done_d;
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// tb/tb_pe_result_drain.sv - scoreboard bench for pe_result_drain
module tb_pe_result_drain;
  import pe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_out_valid;
  logic [23:0] data_out;
  logic        device_out_valid;
  logic        device_out_ready;
  logic [15:0] device_out_data;
  logic [3:0]  device_out_idx;
  logic        device_out_last;
  logic        vector_done;
  logic        overflow;
  logic        busy;

  pe_result_drain dut (
    .clk              (clk),
    .rst              (rst),
    .data_out_valid   (data_out_valid),
    .data_out         (data_out),
    .device_out_valid (device_out_valid),
    .device_out_ready (device_out_ready),
    .device_out_data  (device_out_data),
    .device_out_idx   (device_out_idx),
    .device_out_last  (device_out_last),
    .vector_done      (vector_done),
    .overflow         (overflow),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_idx;
  logic       ovf_exp;
  logic       vd_exp;
  int         n_err = 0;
  int         n_chk = 0;
  int         vd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] quant(input logic [23:0] d);
    int s;
    s = int'($signed(d));
    s = s >>> 4;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic model_reset();
    sb.delete();
    m_idx   = 4'd0;
    ovf_exp = 1'b0;
    vd_exp  = 1'b0;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [23:0] d, input logic r);
    exp_t e;
    logic popped;
    data_out_valid   = v;
    data_out         = d;
    device_out_ready = r;
    #1;
    chk("head_valid", device_out_valid, sb.size() != 0);
    chk("vector_done", vector_done, vd_exp);
    chk("overflow", overflow, ovf_exp);
    popped = (sb.size() != 0) && r;
    vd_exp = 1'b0;
    if (popped) begin
      e = sb.pop_front();
      chk("head_data", device_out_data, e.data);
      chk("head_idx", device_out_idx, e.idx);
      chk("head_last", device_out_last, e.last);
      vd_exp = e.last;
    end
    if (v) begin
      if (sb.size() < DEPTH) sb.push_back('{data: quant(d), idx: m_idx, last: (m_idx == 4'd15)});
      else ovf_exp = 1'b1;
      m_idx = m_idx + 4'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    data_out_valid = 1'b0;
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    data_out_valid = 1'b1;
    data_out = 24'h012345;
    device_out_ready = 1'b1;
    model_reset();

    // Reset held with strobes active
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", device_out_valid, 0);
    chk("rst_data", device_out_data, 0);
    chk("rst_idx", device_out_idx, 0);
    chk("rst_last", device_out_last, 0);
    chk("rst_vdone", vector_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    data_out_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // One full vector with the device always ready
    for (int k = 0; k < 16; k++) step(1'b1, 24'(k * 32), 1'b1);
    chk("busy_mid", busy, 1);
    chk("last_head", device_out_data, 16'd30);
    step(1'b0, 24'h0, 1'b1);
    chk("busy_after", busy, 0);
    chk("vdone_pulse", vector_done, 1);
    step(1'b0, 24'h0, 1'b1);

    // Saturation and floor rounding
    step(1'b1, 24'h7FFFFF, 1'b1);
    chk("sat_max", device_out_data, 16'h7FFF);
    step(1'b1, 24'h800000, 1'b1);
    chk("sat_min", device_out_data, 16'h8000);
    step(1'b1, 24'hFFFFEF, 1'b1);
    chk("floor_neg", device_out_data, 16'hFFFE);
    step(1'b0, 24'h0, 1'b1);

    // Backpressure: 4 buffered, 5th and 6th dropped
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 24'(k * 16 + 8), 1'b0);
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < 4; k++) step(1'b0, 24'h0, 1'b1);
    step(1'b1, 24'h000100, 1'b1);
    chk("idx_after_drop", device_out_idx, 6);
    step(1'b0, 24'h0, 1'b1);
    step(1'b0, 24'h0, 1'b0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 24'(k * 48), 1'b0);
    for (int k = 4; k < 10; k++) begin
      step(1'b1, 24'(k * 48), 1'b1);
      chk("full_count", 32'(dut.u_fifo.count_q), 4);
    end
    chk("full_no_ovf", overflow, 0);
    for (int k = 0; k < 4; k++) step(1'b0, 24'h0, 1'b1);
    step(1'b0, 24'h0, 1'b0);

    // Back-to-back vectors never revisit IDLE
    do_reset();
    vd_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 24'($urandom_range(0, 24'hFFFFFF)), 1'b1);
      chk("no_idle", 32'(dut.state_q != ST_IDLE), 1);
      if (vector_done) vd_cnt++;
    end
    repeat (2) begin
      step(1'b0, 24'h0, 1'b1);
      if (vector_done) vd_cnt++;
    end
    chk("vdone_count", vd_cnt, 2);

    // Reset mid-vector at element 7
    for (int k = 0; k < 7; k++) step(1'b1, 24'(k * 64), 1'b1);
    rst = 1'b0;
    data_out_valid = 1'b0;
    #1;
    chk("midrst_valid", device_out_valid, 0);
    chk("midrst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 24'h000400, 1'b1);
    chk("midrst_idx", device_out_idx, 0);
    step(1'b0, 24'h0, 1'b1);
    step(1'b0, 24'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
